// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions: codeword geometry, bit positions and
// the scrubber FSM state encoding.
package ham_pkg;

   localparam int CW_W   = 7;
   localparam int DATA_W = 4;

   // Codeword bit i carries Hamming position i+1.
   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int D0 = 2;
   localparam int P4 = 3;
   localparam int D1 = 4;
   localparam int D2 = 5;
   localparam int D3 = 6;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CHK  = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/ham_syndrome.sv
// Combinational Hamming(7,4) syndrome and single-bit correction.
// A non-zero syndrome names the 1-based position of the bit to flip.
module ham_syndrome
   import ham_pkg::*;
(
   input  logic [CW_W-1:0] cw,
   output logic [2:0]      syndrome,
   output logic [CW_W-1:0] corrected
);

   logic [CW_W-1:0] flip;

   always_comb begin
      syndrome[0] = cw[P1] ^ cw[D0] ^ cw[D1] ^ cw[D3];
      syndrome[1] = cw[P2] ^ cw[D0] ^ cw[D2] ^ cw[D3];
      syndrome[2] = cw[P4] ^ cw[D1] ^ cw[D2] ^ cw[D3];
      flip = '0;
      if (syndrome != 3'd0) begin
         flip = CW_W'(1) << (syndrome - 3'd1);
      end
      corrected = cw ^ flip;
   end

endmodule

// File: rtl/ham_scrub_ctrl.sv
// Background scrubber: reads every word, writes back the single-bit
// corrected codeword when the syndrome is non-zero, yielding to the host.
module ham_scrub_ctrl
   import ham_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              host_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [CW_W-1:0]   mem_rd_data,
   output logic              mem_wr_en,
   output logic [CW_W-1:0]   mem_wr_data,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [ADDR_W-1:0] last_err_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [CW_W-1:0]   corr_q;
   logic [2:0]        syn;
   logic [CW_W-1:0]   corr_w;
   logic              clr_scan;
   logic              adv;
   logic              load_corr;
   logic              wr_commit;

   ham_syndrome u_syn (
      .cw        (mem_rd_data),
      .syndrome  (syn),
      .corrected (corr_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      clr_scan    = 1'b0;
      adv         = 1'b0;
      load_corr   = 1'b0;
      wr_commit   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               clr_scan  = 1'b1;
               state_nxt = ST_RD;
            end
         end
         ST_RD: begin
            mem_addr = addr;
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (!host_req) begin
               mem_rd_en = 1'b1;
               state_nxt = ST_CHK;
            end
         end
         ST_CHK: begin
            if (syn == 3'd0) begin
               adv = 1'b1;
            end else begin
               load_corr = 1'b1;
               state_nxt = ST_WR;
            end
         end
         ST_WR: begin
            mem_wr_en   = 1'b1;
            mem_addr    = addr;
            mem_wr_data = corr_q;
            wr_commit   = 1'b1;
            adv         = 1'b1;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (adv) begin
         state_nxt = (addr == LAST) ? ST_DONE : ST_RD;
      end
      // A reset arriving mid-access must not let the strobe escape this cycle.
      if (rst) begin
         mem_rd_en = 1'b0;
         mem_wr_en = 1'b0;
      end
      busy = (state != ST_IDLE);
      done = (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr          <= '0;
         corr_q        <= '0;
         corr_cnt      <= '0;
         last_err_addr <= '0;
      end else begin
         if (clr_scan) begin
            addr     <= '0;
            corr_cnt <= '0;
         end
         if (adv && (addr != LAST)) begin
            addr <= addr + 1'b1;
         end
         if (load_corr) begin
            corr_q <= corr_w;
         end
         if (wr_commit) begin
            if (corr_cnt != '1) begin
               corr_cnt <= corr_cnt + 1'b1;
            end
            last_err_addr <= addr;
         end
      end
   end

endmodule

// File: tb/tb_ham_scrub_ctrl.sv
// Directed bench for ham_scrub_ctrl: a default instance plus a CNT_W=2
// instance for saturation, each with its own registered memory model.
module tb_ham_scrub_ctrl;

   localparam logic [6:0] GOOD = 7'b1010101;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic       abort = 1'b0;
   logic       host_req = 1'b0;
   logic       load = 1'b0;
   logic       sel = 1'b0;

   logic [3:0] mem_addr0, mem_addr1, last_err0, last_err1;
   logic       mem_rd_en0, mem_rd_en1, mem_wr_en0, mem_wr_en1;
   logic [6:0] rd_data0, rd_data1, wr_data0, wr_data1;
   logic       busy0, busy1, done0, done1;
   logic [7:0] corr_cnt0;
   logic [1:0] corr_cnt1;

   logic [6:0] mem0 [16];
   logic [6:0] mem1 [16];
   logic [6:0] init0 [16];
   logic [6:0] init1 [16];

   logic [10:0] exp_q [$];
   logic [10:0] wr_q [$];

   int n_tests = 0;
   int n_fail  = 0;
   int done_at, n_rd, n_wr, n_stall_rd, n_overlap, n_cyc;

   wire [3:0] s_addr    = sel ? mem_addr1  : mem_addr0;
   wire       s_rd_en   = sel ? mem_rd_en1 : mem_rd_en0;
   wire       s_wr_en   = sel ? mem_wr_en1 : mem_wr_en0;
   wire [6:0] s_wr_data = sel ? wr_data1   : wr_data0;
   wire       s_busy    = sel ? busy1      : busy0;
   wire       s_done    = sel ? done1      : done0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   ham_scrub_ctrl dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort), .host_req(host_req),
      .mem_addr(mem_addr0), .mem_rd_en(mem_rd_en0), .mem_rd_data(rd_data0),
      .mem_wr_en(mem_wr_en0), .mem_wr_data(wr_data0), .busy(busy0), .done(done0),
      .corr_cnt(corr_cnt0), .last_err_addr(last_err0)
   );

   ham_scrub_ctrl #(.CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort), .host_req(host_req),
      .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1), .mem_rd_data(rd_data1),
      .mem_wr_en(mem_wr_en1), .mem_wr_data(wr_data1), .busy(busy1), .done(done1),
      .corr_cnt(corr_cnt1), .last_err_addr(last_err1)
   );

   always @(posedge clk) begin
      if (load) begin
         mem0 <= init0;
         mem1 <= init1;
      end else begin
         if (mem_rd_en0) rd_data0 <= mem0[mem_addr0];
         if (mem_wr_en0) mem0[mem_addr0] <= wr_data0;
         if (mem_rd_en1) rd_data1 <= mem1[mem_addr1];
         if (mem_wr_en1) mem1[mem_addr1] <= wr_data1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fill_clean();
      for (int i = 0; i < 16; i++) begin
         init0[i] = GOOD;
         init1[i] = GOOD;
      end
   endtask

   task automatic do_load();
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
   endtask

   // Cycle 0 is the cycle in which start is sampled; cyc counts from there.
   task automatic run_scan(input bit which, input int hreq_at, input int hreq_len,
                           input int abort_at);
      sel = which;
      done_at = -1; n_rd = 0; n_wr = 0; n_stall_rd = 0; n_overlap = 0; n_cyc = 0;
      wr_q.delete();
      @(negedge clk);
      if (which) start1 = 1'b1; else start0 = 1'b1;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         @(negedge clk);
         start0   = 1'b0;
         start1   = 1'b0;
         host_req = (cyc >= hreq_at) && (cyc < hreq_at + hreq_len);
         abort    = (cyc == abort_at);
         #1;
         if (s_rd_en) n_rd++;
         if (s_rd_en && host_req) n_stall_rd++;
         if (s_rd_en && s_wr_en) n_overlap++;
         if (s_wr_en) begin
            n_wr++;
            wr_q.push_back({s_addr, s_wr_data});
         end
         if (s_done) done_at = cyc;
         n_cyc = cyc;
         if (!s_busy) break;
      end
      host_req = 1'b0;
      abort    = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if ({mem_rd_en0, mem_wr_en0, busy0, done0} !== 4'b0) begin
         n_fail++; $display("FAIL reset_strobes got=%b want=0000", {mem_rd_en0, mem_wr_en0, busy0, done0});
      end
      n_tests++;
      if ({mem_addr0, wr_data0} !== 11'd0) begin
         n_fail++; $display("FAIL reset_addr_data got=%h want=0", {mem_addr0, wr_data0});
      end
      n_tests++;
      if ({corr_cnt0, last_err0} !== 12'd0) begin
         n_fail++; $display("FAIL reset_counters got=%h want=0", {corr_cnt0, last_err0});
      end
   endtask

   task automatic check_writes(input string name);
      n_tests++;
      if (wr_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL %s_write_count got=%0d want=%0d", name, wr_q.size(), exp_q.size());
      end else begin
         while (exp_q.size() > 0) begin
            logic [10:0] e, g;
            e = exp_q.pop_front();
            g = wr_q.pop_front();
            n_tests++;
            if (g !== e) begin
               n_fail++; $display("FAIL %s_write got=%h:%b want=%h:%b", name, g[10:7], g[6:0], e[10:7], e[6:0]);
            end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_clean();
      fill_clean(); do_load();
      run_scan(1'b0, 999, 0, -1);
      n_tests++;
      if (done_at !== 33) begin n_fail++; $display("FAIL clean_done_cycle got=%0d want=33", done_at); end
      n_tests++;
      if (n_rd !== 16) begin n_fail++; $display("FAIL clean_reads got=%0d want=16", n_rd); end
      n_tests++;
      if (corr_cnt0 !== 8'd0) begin n_fail++; $display("FAIL clean_corr_cnt got=%0d want=0", corr_cnt0); end
      n_tests++;
      if (n_cyc !== 34) begin n_fail++; $display("FAIL clean_busy_drop got=%0d want=34", n_cyc); end
      check_writes("clean");
   endtask

   task automatic test_single();
      fill_clean(); init0[3] = 7'b1010100; do_load();
      exp_q.push_back({4'd3, GOOD});
      run_scan(1'b0, 999, 0, -1);
      n_tests++;
      if (done_at !== 34) begin n_fail++; $display("FAIL single_done_cycle got=%0d want=34", done_at); end
      n_tests++;
      if (corr_cnt0 !== 8'd1) begin n_fail++; $display("FAIL single_corr_cnt got=%0d want=1", corr_cnt0); end
      n_tests++;
      if (last_err0 !== 4'd3) begin n_fail++; $display("FAIL single_last_err got=%0d want=3", last_err0); end
      n_tests++;
      if (mem0[3] !== GOOD) begin n_fail++; $display("FAIL single_mem3 got=%b want=%b", mem0[3], GOOD); end
      check_writes("single");
   endtask

   task automatic test_double();
      fill_clean(); init0[7] = 7'b0010101; init0[12] = 7'b1010001; do_load();
      exp_q.push_back({4'd7, GOOD});
      exp_q.push_back({4'd12, GOOD});
      run_scan(1'b0, 999, 0, -1);
      n_tests++;
      if (done_at !== 35) begin n_fail++; $display("FAIL double_done_cycle got=%0d want=35", done_at); end
      n_tests++;
      if (corr_cnt0 !== 8'd2) begin n_fail++; $display("FAIL double_corr_cnt got=%0d want=2", corr_cnt0); end
      n_tests++;
      if (last_err0 !== 4'd12) begin n_fail++; $display("FAIL double_last_err got=%0d want=12", last_err0); end
      n_tests++;
      if (n_overlap !== 0) begin n_fail++; $display("FAIL double_strobe_overlap got=%0d want=0", n_overlap); end
      check_writes("double");
   endtask

   task automatic test_host_stall();
      n_tests++;
      if ({corr_cnt0, last_err0} !== {8'd2, 4'd12}) begin
         n_fail++; $display("FAIL hold_between_scans got=%0d/%0d want=2/12", corr_cnt0, last_err0);
      end
      fill_clean(); do_load();
      // Address 5 is in RD during cycle 11 of an error-free scan.
      run_scan(1'b0, 11, 5, -1);
      n_tests++;
      if (done_at !== 38) begin n_fail++; $display("FAIL stall_done_cycle got=%0d want=38", done_at); end
      n_tests++;
      if (n_stall_rd !== 0) begin n_fail++; $display("FAIL stall_rd_during_req got=%0d want=0", n_stall_rd); end
      n_tests++;
      if (n_rd !== 16) begin n_fail++; $display("FAIL stall_reads got=%0d want=16", n_rd); end
      n_tests++;
      if ({corr_cnt0, last_err0} !== {8'd0, 4'd12}) begin
         n_fail++; $display("FAIL stall_counters got=%0d/%0d want=0/12", corr_cnt0, last_err0);
      end
   endtask

   task automatic test_abort();
      fill_clean(); do_load();
      // Address 9 is in RD during cycle 19.
      run_scan(1'b0, 999, 0, 19);
      n_tests++;
      if (n_rd !== 9) begin n_fail++; $display("FAIL abort_reads got=%0d want=9", n_rd); end
      n_tests++;
      if (done_at !== -1) begin n_fail++; $display("FAIL abort_done got=%0d want=-1", done_at); end
      n_tests++;
      if (n_cyc !== 20) begin n_fail++; $display("FAIL abort_busy_drop got=%0d want=20", n_cyc); end
   endtask

   task automatic test_rst_in_wr();
      fill_clean(); init0[3] = 7'b1010100; do_load();
      sel = 1'b0;
      @(negedge clk) start0 = 1'b1;
      // RD addr3 in cycle 7, CHK in 8, WR in 9.
      repeat (9) begin
         @(negedge clk);
         start0 = 1'b0;
      end
      #1;
      n_tests++;
      if ({mem_wr_en0, mem_addr0} !== {1'b1, 4'd3}) begin
         n_fail++; $display("FAIL rst_pre_wr got=%b/%0d want=1/3", mem_wr_en0, mem_addr0);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (mem_wr_en0 !== 1'b0) begin n_fail++; $display("FAIL rst_wr_blocked got=%b want=0", mem_wr_en0); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if ({busy0, mem_rd_en0, mem_wr_en0, done0, mem_addr0, wr_data0} !== 15'd0) begin
         n_fail++; $display("FAIL rst_outputs got=%h want=0", {busy0, mem_rd_en0, mem_wr_en0, done0, mem_addr0, wr_data0});
      end
      n_tests++;
      if ({corr_cnt0, last_err0} !== 12'd0) begin
         n_fail++; $display("FAIL rst_counters got=%0d/%0d want=0/0", corr_cnt0, last_err0);
      end
      n_tests++;
      if (mem0[3] !== 7'b1010100) begin n_fail++; $display("FAIL rst_mem3 got=%b want=1010100", mem0[3]); end
   endtask

   task automatic test_saturate();
      fill_clean();
      init1[1]  = 7'b1010111;
      init1[2]  = 7'b1011101;
      init1[4]  = 7'b1000101;
      init1[8]  = 7'b1110101;
      init1[15] = 7'b0010101;
      do_load();
      exp_q.push_back({4'd1, GOOD});
      exp_q.push_back({4'd2, GOOD});
      exp_q.push_back({4'd4, GOOD});
      exp_q.push_back({4'd8, GOOD});
      exp_q.push_back({4'd15, GOOD});
      run_scan(1'b1, 999, 0, -1);
      n_tests++;
      if (corr_cnt1 !== 2'd3) begin n_fail++; $display("FAIL sat_corr_cnt got=%0d want=3", corr_cnt1); end
      n_tests++;
      if (done_at !== 38) begin n_fail++; $display("FAIL sat_done_cycle got=%0d want=38", done_at); end
      n_tests++;
      if (last_err1 !== 4'd15) begin n_fail++; $display("FAIL sat_last_err got=%0d want=15", last_err1); end
      check_writes("sat");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      fill_clean();
      test_reset();
      test_clean();
      test_single();
      test_double();
      test_host_stall();
      test_abort();
      test_rst_in_wr();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ham_scrub_ctrl.md
Name: ham_scrub_ctrl

Overview:
- Background scrubber controller for a Hamming(7,4)-protected codeword memory.
- On start, walks every address. For each word it issues a read, computes the syndrome, and writes back the single-bit-corrected codeword when the syndrome is non-zero.
- Yields the memory port to the host whenever the host requests it.
- Sits beside ham_encoder: the encoder fills the memory, this block keeps it clean.

Parameters:
- ADDR_W, 4, memory address width.
- DEPTH, 16, number of words scanned (addresses 0..DEPTH-1, DEPTH <= 2**ADDR_W).
- CNT_W, 8, width of the correction counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- abort  in  1  end the scan early; honoured only in RD.
- host_req  in  1  host needs the memory port; scrubber must not start a new access.
- mem_addr  out  ADDR_W  memory address.
- mem_rd_en  out  1  read strobe; mem_rd_data is valid the next cycle.
- mem_rd_data  in  7  codeword read.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  7  corrected codeword.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a full scan completes.
- corr_cnt  out  CNT_W  corrections made in the current/last scan; saturating.
- last_err_addr  out  ADDR_W  address of the most recent correction.

Behaviour:
- Codeword layout: bit i holds Hamming position i+1.
  - Parity bits are at bits 0, 1, 3.
  - Data bits: d3 at bit 6, d2 at bit 5, d1 at bit 4, d0 at bit 2.
  - Example: data 1011 encodes to 1010101.
- Syndrome s = {s4, s2, s1}, even parity:
  - s1 = ^bits{0,2,4,6}
  - s2 = ^bits{1,2,5,6}
  - s4 = ^bits{3,4,5,6}
  - s != 0 means flip bit s-1. Double errors are indistinguishable and are "corrected" the same way; no DED.
- Reset: state IDLE; mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, busy, done, corr_cnt and last_err_addr all 0.
- States:
  - IDLE: start=1 clears corr_cnt and the address counter, then goes to RD.
  - RD: if abort=1, go to IDLE with no done and no access. Otherwise, if host_req=1, stay with mem_rd_en=0 (stall). Otherwise assert mem_rd_en for one cycle with mem_addr=addr, then go to CHK.
  - CHK: computes the syndrome from mem_rd_data combinationally.
    - s==0: advance.
    - s!=0: register the corrected word, go to WR.
  - WR: assert mem_wr_en with mem_wr_data = corrected word and mem_addr = same addr; corr_cnt++ (saturates at 2**CNT_W-1); last_err_addr = addr; then advance. A write is never deferred for host_req, because host_req blocks only new reads.
  - advance: if addr == DEPTH-1, go to DONE; otherwise addr+1 and go to RD.
  - DONE: done=1 for one cycle, then IDLE.
- Timing: with no stalls and N corrections, start is sampled in cycle 0 and done is high in cycle 2*DEPTH+N+1.
- Strobes: mem_rd_en and mem_wr_en are never high together. Both are 0 outside RD and WR.
- start while busy is ignored. abort outside RD is ignored.
- rst mid-scan returns to IDLE immediately with no write issued. corr_cnt and last_err_addr hold their values until the next start, except on rst, which clears them.

Decomposition:
- Package ham_pkg holds:
  - CW_W=7 and DATA_W=4.
  - Bit-position constants: P1=0, P2=1, D0=2, P4=3, D1=4, D2=5, D3=6.
  - An enum for the FSM states.
- Sub-module ham_syndrome (combinational): cw[6:0] in; syndrome[2:0] and corrected[6:0] out. Reusable later by a standalone decoder.

Test Plan:
- Memory preloaded with 1010101 at all 16 addresses, start pulse → 16 reads, no writes, done in cycle 33, corr_cnt=0.
- Address 3 holds 1010100 (bit 0 flipped) → syndrome 001, one write of 1010101 to address 3, corr_cnt=1, last_err_addr=3, done in cycle 34.
- Address 7 has bit 6 flipped (0010101) and address 12 has bit 2 flipped (1010001) → writes 1010101 to addresses 7 and 12, corr_cnt=2, last_err_addr=12.
- host_req held high for 5 cycles while in RD at address 5 → mem_rd_en stays 0 for those 5 cycles, then resumes; done is delayed by exactly 5 cycles.
- abort asserted in RD at address 9 → returns to IDLE, no done, busy drops next cycle; rst asserted during WR → no mem_wr_en that cycle, all outputs 0.
- CNT_W=2 with 5 corrupted words → corr_cnt saturates at 3.
